// File: rtl/web_refill_station.sv
// web_refill_station: responder side of the shooter refill exchange.
// Keeps a bulk fluid reservoir. A refill request is either granted, after
// which units stream out one per valid/ready beat, or denied.
// Optional build macro: PARTIAL_FILL_EN. When defined, a shortfall with a
// non-empty reservoir grants whatever the reservoir holds instead of denying.
//
// Handshake: a unit moves on every rising edge where unit_valid and
// unit_ready are both high. unit_valid, once raised, stays high with no
// change until the unit is taken, the grant completes, or req drops.
module web_refill_station #(
  parameter int RES_W    = 9,
  parameter int RES_INIT = 256,
  parameter int RES_MAX  = 256,
  parameter int AMT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [AMT_W-1:0] req_amount,
  output logic             unit_valid,
  input  logic             unit_ready,
  output logic             busy,
  output logic             done,
  output logic             deny,
  output logic [AMT_W-1:0] remaining,
  output logic [RES_W-1:0] level,
  input  logic             restock,
  input  logic [RES_W-1:0] restock_amount
);

  // DONE_WAIT holds after the done pulse until the requester drops req.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DISPENSE,
    S_DONE,
    S_DONE_WAIT,
    S_DENY
  } state_t;

  localparam logic [RES_W:0]   MAX_EXT  = (RES_W+1)'(RES_MAX);
  localparam logic [RES_W-1:0] INIT_LVL = RES_W'(RES_INIT);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [RES_W-1:0] level_q, level_d;
  logic             unit_valid_q, busy_q, done_q, deny_q;
  logic             beat;
  logic [RES_W:0]   level_ext;

  // A unit leaves the station only while it is being offered.
  assign beat = unit_valid_q & unit_ready;

  // Next-state and grant bookkeeping for the refill transaction.
  always_comb begin
    state_d     = state_q;
    amt_d       = amt_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          amt_d   = req_amount;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (amt_q == '0) begin
          state_d = S_DENY;
        end else if (RES_W'(amt_q) <= level_q) begin
          state_d     = S_DISPENSE;
          remaining_d = amt_q;
`ifdef PARTIAL_FILL_EN
        end else if (level_q != '0) begin
          // level is below amt here, so it fits in the amount width.
          state_d     = S_DISPENSE;
          remaining_d = level_q[AMT_W-1:0];
`endif
        end else begin
          state_d = S_DENY;
        end
      end
      S_DISPENSE: begin
        if (beat) remaining_d = remaining_q - 1'b1;
        if (!req) begin
          // Abort: a beat in this cycle still counts against level.
          state_d     = S_IDLE;
          remaining_d = '0;
        end else if (beat && remaining_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:      state_d = req ? S_DONE_WAIT : S_IDLE;
      S_DONE_WAIT: if (!req) state_d = S_IDLE;
      S_DENY:      if (!req) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Reservoir update: restock and beat combine, saturating at the ceiling.
  always_comb begin
    level_ext = {1'b0, level_q};
    if (restock) level_ext = level_ext + {1'b0, restock_amount};
    if (beat)    level_ext = level_ext - 1'b1;
    level_d = (level_ext > MAX_EXT) ? RES_W'(RES_MAX) : level_ext[RES_W-1:0];
  end

  // State, reservoir and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      amt_q        <= '0;
      remaining_q  <= '0;
      level_q      <= INIT_LVL;
      unit_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      deny_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      amt_q        <= amt_d;
      remaining_q  <= remaining_d;
      level_q      <= level_d;
      unit_valid_q <= (state_d == S_DISPENSE);
      busy_q       <= (state_d == S_CHECK) || (state_d == S_DISPENSE);
      done_q       <= (state_d == S_DONE);
      deny_q       <= (state_d == S_DENY);
    end
  end

  assign unit_valid = unit_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign deny       = deny_q;
  assign remaining  = remaining_q;
  assign level      = level_q;

endmodule
